// File: rtl/term_monitor_pkg.sv
// Shared types and helpers for the terminated-input monitor.
// Holds the per-channel FSM state encoding and the saturating counter increment.
package term_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StTripped = 2'd2
  } ch_state_e;

  // Widest activity counter the helper supports.
  localparam int unsigned MaxCntW = 32;

  // Increment val, holding at 2^width-1 instead of wrapping.
  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] val,
                                                 input int unsigned        width);
    logic [MaxCntW:0] max_val;
    max_val = ({{MaxCntW{1'b0}}, 1'b1} << width) - {{MaxCntW{1'b0}}, 1'b1};
    if ({1'b0, val} >= max_val) begin
      return val;
    end
    return val + {{(MaxCntW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/term_monitor_ch.sv
// One monitor channel: IDLE/ARMED/TRIPPED FSM, input sample register,
// saturating toggle counter and sticky activity flag.
module term_monitor_ch
  import term_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tie_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] i,
  output logic [CNT_W-1:0] act_cnt,
  output logic             act_flag,
  output logic             flag_next
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             toggle;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    // Compare against the sample only once armed; the arming edge just loads it.
    toggle   = (state_q != StIdle) && (i != sample_q);

    if (tie_en || (state_q != StIdle)) begin
      sample_d = i;
    end

    if (!tie_en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    state_d = StArmed;
        StArmed:   if (toggle && !clr) state_d = StTripped;
        StTripped: if (clr) state_d = StArmed;
        default:   state_d = StIdle;
      endcase
    end

    // Clear beats a same-cycle toggle.
    if (clr) begin
      cnt_d = '0;
    end else if (toggle) begin
      cnt_d = CNT_W'(sat_inc(MaxCntW'(cnt_q), CNT_W));
    end

    flag_d = (state_d == StTripped) || ((state_d == StIdle) && (cnt_d != '0));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      sample_q <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
    end
  end

  assign act_cnt   = cnt_q;
  assign act_flag  = flag_q;
  assign flag_next = flag_d;

endmodule

// File: rtl/term_monitor.sv
// Multi-channel monitor for terminated inputs: ties or passes each output
// channel and raises a registered interrupt when any terminated input toggles.
module term_monitor
  import term_monitor_pkg::*;
#(
  parameter int unsigned     N_CH    = 4,
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     CNT_W   = 8,
  parameter logic [WIDTH-1:0] TIE_VAL = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_CH*WIDTH-1:0] i,
  input  logic [N_CH*WIDTH-1:0] pass_i,
  input  logic [N_CH-1:0]       tie_en,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH*WIDTH-1:0] o,
  output logic [N_CH*CNT_W-1:0] act_cnt,
  output logic [N_CH-1:0]       act_flag,
  output logic                  irq
);

  logic [N_CH*WIDTH-1:0] o_q, o_d;
  logic [N_CH-1:0]       flag_next;
  logic                  irq_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    term_monitor_ch #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .tie_en    (tie_en[c]),
      .clr       (clr[c]),
      .i         (i[c*WIDTH +: WIDTH]),
      .act_cnt   (act_cnt[c*CNT_W +: CNT_W]),
      .act_flag  (act_flag[c]),
      .flag_next (flag_next[c])
    );
  end

  always_comb begin
    o_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      o_d[c*WIDTH +: WIDTH] = tie_en[c] ? TIE_VAL : pass_i[c*WIDTH +: WIDTH];
    end
  end

  // IRQ is built from next-state flags so it rises together with ACT_FLAG.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_q   <= '0;
      irq_q <= 1'b0;
    end else begin
      o_q   <= o_d;
      irq_q <= |flag_next;
    end
  end

  assign o   = o_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_term_monitor.sv
// Directed self-checking bench for term_monitor (4 channels, 1 bit, 3-bit counters).
module tb_term_monitor;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned WIDTH = 1;
  localparam int unsigned CNT_W = 3;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [N_CH*WIDTH-1:0] i;
  logic [N_CH*WIDTH-1:0] pass_i;
  logic [N_CH-1:0]       tie_en;
  logic [N_CH-1:0]       clr;
  logic [N_CH*WIDTH-1:0] o;
  logic [N_CH*CNT_W-1:0] act_cnt;
  logic [N_CH-1:0]       act_flag;
  logic                  irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_cnt [N_CH];

  term_monitor #(
    .N_CH    (N_CH),
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .TIE_VAL (1'b0)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i        (i),
    .pass_i   (pass_i),
    .tie_en   (tie_en),
    .clr      (clr),
    .o        (o),
    .act_cnt  (act_cnt),
    .act_flag (act_flag),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CH*CNT_W-1:0] packed_cnt();
    logic [N_CH*CNT_W-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(exp_cnt[c]);
    return v;
  endfunction

  task automatic check_all(input string tag, input logic [3:0] exp_o,
                           input logic [3:0] exp_flag, input logic exp_irq);
    check({tag, ".o"}, 32'(o), 32'(exp_o));
    check({tag, ".cnt"}, 32'(act_cnt), 32'(packed_cnt()));
    check({tag, ".flag"}, 32'(act_flag), 32'(exp_flag));
    check({tag, ".irq"}, 32'(irq), 32'(exp_irq));
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) exp_cnt[c] = 0;
    resetn = 1'b0;
    i      = '0;
    pass_i = '0;
    tie_en = '0;
    clr    = '0;
    tick();
    tick();
    check_all("reset", 4'b0000, 4'b0000, 1'b0);

    // Pass-through after reset release.
    resetn = 1'b1;
    pass_i = 4'b1010;
    tick();
    check_all("pass", 4'b1010, 4'b0000, 1'b0);

    // Tie channel 0 with a constant high input: priming must not count.
    pass_i = 4'b1011;
    tie_en = 4'b0001;
    i      = 4'b0001;
    tick();
    check_all("prime0", 4'b1010, 4'b0000, 1'b0);
    tick();
    tick();
    tick();
    check_all("hold0", 4'b1010, 4'b0000, 1'b0);

    // Trip channel 0 with 1->0->1.
    i[0] = 1'b0;
    tick();
    exp_cnt[0] = 1;
    check_all("trip1", 4'b1010, 4'b0001, 1'b1);
    i[0] = 1'b1;
    tick();
    exp_cnt[0] = 2;
    check_all("trip2", 4'b1010, 4'b0001, 1'b1);
    tick();
    check_all("trip_hold", 4'b1010, 4'b0001, 1'b1);

    // Clear collides with a toggle: clear wins, later toggle counts 1.
    i[0] = 1'b0;
    clr  = 4'b0001;
    tick();
    exp_cnt[0] = 0;
    check_all("clr_coll", 4'b1010, 4'b0000, 1'b0);
    clr  = 4'b0000;
    i[0] = 1'b1;
    tick();
    exp_cnt[0] = 1;
    check_all("clr_after", 4'b1010, 4'b0001, 1'b1);

    // Channel 1 saturation at 7 with a 3-bit counter.
    tie_en = 4'b0011;
    tick();
    check_all("prime1", 4'b1000, 4'b0001, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      i[1] = k[0];
      tick();
      exp_cnt[1] = (k > 7) ? 7 : k;
      check($sformatf("sat%0d", k), 32'(act_cnt), 32'(packed_cnt()));
    end
    check("sat.flag", 32'(act_flag), 32'(4'b0011));

    // Channel 0 back to IDLE: count and flag held, output passes again.
    tie_en = 4'b0010;
    tick();
    check_all("idle_hold", 4'b1001, 4'b0011, 1'b1);

    // Channel 2 to TRIPPED with count 5.
    tie_en = 4'b0110;
    tick();
    check_all("prime2", 4'b1001, 4'b0011, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      i[2] = k[0];
      tick();
    end
    exp_cnt[2] = 5;
    check_all("trip2_5", 4'b1001, 4'b0111, 1'b1);

    // One-cycle reset pulse mid-operation.
    resetn = 1'b0;
    tick();
    for (int c = 0; c < N_CH; c++) exp_cnt[c] = 0;
    check_all("midrst", 4'b0000, 4'b0000, 1'b0);
    resetn = 1'b1;
    tick();
    check_all("reprime", 4'b1001, 4'b0000, 1'b0);
    i[2] = 1'b0;
    tick();
    exp_cnt[2] = 1;
    check_all("rearmed", 4'b1001, 4'b0100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
